// File: rtl/pkg_cpu_typedefs.sv
// Shared RV32I core type definitions.
package pkg_cpu_typedefs;

  localparam int unsigned ALU_OP_W = 3;

  // ALU operation select consumed by the ALU datapath
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_opcode_t;

endpackage

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle main control unit of the RV32I core: sequences fetch, decode,
// execute, memory and writeback and drives the datapath selects and strobes.
module cpu_ctrl_fsm
  import pkg_cpu_typedefs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_ctrl,
  output logic       instr_done,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_MEM      = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  alu_opcode_t funct_op;
  alu_opcode_t alu_op;
  logic        alu_funct_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // ALU operation implied by funct3/funct7; only R-type honours funct7b5
  always_comb begin
    funct_op     = ALU_ADD;
    alu_funct_ok = 1'b1;
    case (funct3)
      3'b000:  funct_op = ((op == OP_RTYPE) && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_op = ALU_SLT;
      3'b110:  funct_op = ALU_OR;
      3'b111:  funct_op = ALU_AND;
      default: alu_funct_ok = 1'b0;
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  assign alu_ctrl = alu_op;

  // Next state and datapath controls; reset masks every control to its default
  always_comb begin
    state_nxt     = state;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    adr_src       = 1'b0;
    result_src    = RES_ALU_OUT;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;

    if (rst) begin
      state_nxt = S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          adr_src    = 1'b0;
          alu_src_a  = SRC_A_PC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_rdy;
          pc_write   = mem_rdy;
          if (mem_rdy) begin
            state_nxt = S_DECODE;
          end
        end

        // ALU precomputes oldPC + imm as the branch/jump target
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          case (op)
            OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
            OP_RTYPE:          state_nxt = alu_funct_ok ? S_EXEC_R : S_TRAP;
            OP_ITYPE:          state_nxt = alu_funct_ok ? S_EXEC_I : S_TRAP;
            OP_BRANCH:         state_nxt = (funct3 == 3'b000) ? S_BRANCH : S_TRAP;
            OP_JAL:            state_nxt = S_JAL;
            default:           state_nxt = S_TRAP;
          endcase
        end

        S_MEM_ADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          state_nxt = op[5] ? S_MEM_WRITE : S_MEM_READ;
        end

        S_MEM_READ: begin
          adr_src    = 1'b1;
          result_src = RES_ALU_OUT;
          if (mem_rdy) begin
            state_nxt = S_MEM_WB;
          end
        end

        S_MEM_WB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end

        S_MEM_WRITE: begin
          adr_src    = 1'b1;
          result_src = RES_ALU_OUT;
          mem_write  = 1'b1;
          instr_done = mem_rdy;
          if (mem_rdy) begin
            state_nxt = S_FETCH;
          end
        end

        S_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op    = funct_op;
          state_nxt = S_ALU_WB;
        end

        S_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = funct_op;
          state_nxt = S_ALU_WB;
        end

        S_ALU_WB: begin
          result_src = RES_ALU_OUT;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end

        // Taken when rs1 - rs2 == 0; PC loads the target held in ALUOut
        S_BRANCH: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_RS2;
          alu_op     = ALU_SUB;
          result_src = RES_ALU_OUT;
          pc_write   = zero;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end

        // PC takes the target from ALUOut while the ALU forms oldPC + 4 for rd
        S_JAL: begin
          alu_src_a  = SRC_A_OLD_PC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU_OUT;
          pc_write   = 1'b1;
          state_nxt  = S_ALU_WB;
        end

        S_TRAP: begin
          illegal_instr = 1'b1;
          state_nxt     = S_TRAP;
        end

        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomized self-checking bench for cpu_ctrl_fsm against an instruction-level
// model of the per-cycle control sequence.
module tb_cpu_ctrl_fsm;
  import pkg_cpu_typedefs::*;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_rdy = 1'b0;
  logic        pc_write, ir_write, mem_write, reg_write, adr_src;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_ctrl;
  logic        instr_done, illegal_instr;

  logic [31:0] cur_w = '0;
  logic [17:0] obs;
  int          checks = 0;
  int          errors = 0;

  cpu_ctrl_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_rdy(mem_rdy), .pc_write(pc_write), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_ctrl(alu_ctrl), .instr_done(instr_done),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, ir_write, mem_write, reg_write, adr_src, result_src,
                alu_src_a, alu_src_b, imm_src, alu_ctrl, instr_done, illegal_instr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%05h exp=%05h (pcw irw mw rw adr rs[2] sa[2] sb[2] imm[2] alu[3] done ill)",
               tag, got, exp);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == OP_STORE)  return 2'b01;
    if (o == OP_BRANCH) return 2'b10;
    if (o == OP_JAL)    return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit alu_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic bit is_legal(input logic [6:0] o, input logic [2:0] f3);
    if (o == OP_LOAD || o == OP_STORE || o == OP_JAL) return 1'b1;
    if (o == OP_RTYPE || o == OP_ITYPE) return alu_f3_ok(f3);
    if (o == OP_BRANCH) return f3 == 3'b000;
    return 1'b0;
  endfunction

  function automatic alu_opcode_t alu_for(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b010) return ALU_SLT;
    if (f3 == 3'b110) return ALU_OR;
    if (f3 == 3'b111) return ALU_AND;
    return (o == OP_RTYPE && f7) ? ALU_SUB : ALU_ADD;
  endfunction

  // Expected control vector for one cycle of the current instruction
  function automatic logic [17:0] e(input logic pcw, input logic irw, input logic mw,
                                    input logic rw, input logic adr, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input alu_opcode_t alu, input logic done, input logic ill);
    return {pcw, irw, mw, rw, adr, rs, sa, sb, imm_of(cur_w[6:0]), 3'(alu), done, ill};
  endfunction

  task automatic drive_fields();
    op       = cur_w[6:0];
    funct3   = cur_w[14:12];
    funct7b5 = cur_w[30];
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic z, input logic [17:0] exp);
    @(negedge clk);
    rst     = 1'b0;
    mem_rdy = rdy;
    zero    = z;
    drive_fields();
    #1;
    check(tag, 32'(obs), 32'(exp));
    @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst     = 1'b1;
      mem_rdy = 1'b0;
      zero    = 1'($urandom);
      drive_fields();
      #1;
      check("reset", 32'(obs), 32'(e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0, 0)));
      @(posedge clk);
    end
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc("trap", 1'($urandom), 1'($urandom),
          e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0, 1));
  endtask

  // One whole instruction: fw/mw wait cycles in fetch / memory, z = branch zero flag
  task automatic run_instr(input logic [31:0] w, input int fw, input int mw, input logic z);
    logic [6:0] o;
    logic [2:0] f3;
    logic       rdy;
    cur_w = w;
    o     = w[6:0];
    f3    = w[14:12];
    for (int i = 0; i <= fw; i++) begin
      rdy = (i == fw);
      cyc("fetch", rdy, 1'($urandom),
          e(rdy, rdy, 0, 0, 0, 2'b10, 2'b00, 2'b10, ALU_ADD, 0, 0));
    end
    cyc("decode", 1'($urandom), 1'($urandom),
        e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ALU_ADD, 0, 0));
    if (!is_legal(o, f3)) return;
    if (o == OP_LOAD || o == OP_STORE) begin
      cyc("mem_adr", 1'($urandom), 1'($urandom),
          e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ALU_ADD, 0, 0));
      for (int i = 0; i <= mw; i++) begin
        rdy = (i == mw);
        if (o == OP_LOAD)
          cyc("mem_read", rdy, 1'($urandom),
              e(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ALU_ADD, 0, 0));
        else
          cyc("mem_write", rdy, 1'($urandom),
              e(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, ALU_ADD, rdy, 0));
      end
      if (o == OP_LOAD)
        cyc("mem_wb", 1'($urandom), 1'($urandom),
            e(0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, ALU_ADD, 1, 0));
    end else if (o == OP_RTYPE || o == OP_ITYPE) begin
      cyc("exec", 1'($urandom), 1'($urandom),
          e(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == OP_ITYPE) ? 2'b01 : 2'b00,
            alu_for(o, f3, w[30]), 0, 0));
      cyc("alu_wb", 1'($urandom), 1'($urandom),
          e(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 1, 0));
    end else if (o == OP_BRANCH) begin
      cyc("branch", 1'($urandom), z,
          e(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ALU_SUB, 1, 0));
    end else begin
      cyc("jal", 1'($urandom), 1'($urandom),
          e(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, ALU_ADD, 0, 0));
      cyc("jal_wb", 1'($urandom), 1'($urandom),
          e(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 1, 0));
    end
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    logic [2:0]  f3;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 5);
    case ($urandom_range(0, 3))
      0:       f3 = 3'b000;
      1:       f3 = 3'b010;
      2:       f3 = 3'b110;
      default: f3 = 3'b111;
    endcase
    case (k)
      0:       w[6:0] = OP_LOAD;
      1:       w[6:0] = OP_STORE;
      2:       w[6:0] = OP_RTYPE;
      3:       w[6:0] = OP_ITYPE;
      4:       begin w[6:0] = OP_BRANCH; f3 = 3'b000; end
      default: w[6:0] = OP_JAL;
    endcase
    if (k != 5) w[14:12] = f3;
    return w;
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 2))
      0: begin
        w[6:0] = ($urandom_range(0, 1) == 0) ? OP_RTYPE : OP_ITYPE;
        while (alu_f3_ok(w[14:12])) w[14:12] = 3'($urandom);
      end
      1: begin
        w[6:0] = OP_BRANCH;
        while (w[14:12] == 3'b000) w[14:12] = 3'($urandom);
      end
      default: begin
        while (is_legal(w[6:0], w[14:12])) w[6:0] = 7'($urandom);
      end
    endcase
    return w;
  endfunction

  initial begin
    do_reset(2);

    run_instr(32'h002081B3, 0, 0, 1'b0);  // add
    run_instr(32'h402081B3, 0, 0, 1'b0);  // sub
    run_instr(32'h40008093, 0, 0, 1'b0);  // addi with instr[30]=1
    run_instr(32'h0020A1B3, 0, 0, 1'b0);  // slt
    run_instr(32'h0020E1B3, 0, 0, 1'b0);  // or
    run_instr(32'h0020F1B3, 0, 0, 1'b0);  // and
    run_instr(32'h0000A183, 0, 2, 1'b0);  // lw, two wait states
    run_instr(32'h0030A023, 1, 1, 1'b0);  // sw
    run_instr(32'h00208063, 0, 0, 1'b1);  // beq taken
    run_instr(32'h00208063, 0, 0, 1'b0);  // beq not taken
    run_instr(32'h008000EF, 0, 0, 1'b0);  // jal

    run_instr(32'h0000007F, 0, 0, 1'b0);  // unknown opcode
    trap_cycles(10);
    do_reset(1);
    run_instr(32'h002081B3, 0, 0, 1'b0);

    run_instr(32'h002091B3, 0, 0, 1'b0);  // R-type funct3=001
    trap_cycles(10);
    do_reset(1);
    run_instr(32'h002081B3, 0, 0, 1'b0);

    // Reset while a store is waiting on memory
    cur_w = 32'h0030A023;
    cyc("sw_fetch", 1'b1, 1'b0, e(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, ALU_ADD, 0, 0));
    cyc("sw_decode", 1'b0, 1'b0, e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ALU_ADD, 0, 0));
    cyc("sw_adr", 1'b0, 1'b0, e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ALU_ADD, 0, 0));
    cyc("sw_wait", 1'b0, 1'b0, e(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, ALU_ADD, 0, 0));
    do_reset(1);
    run_instr(32'h0000A183, 1, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        run_instr(rand_illegal(), $urandom_range(0, 2), 0, 1'b0);
        trap_cycles($urandom_range(2, 5));
        do_reset($urandom_range(1, 2));
      end else begin
        run_instr(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle main control unit of the RV32I CPU core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects, write strobes and the ALU operation, encoded as `pkg_cpu_typedefs::alu_opcode_t`. It sits directly upstream of the ALU and register file and consumes the opcode/funct fields of the instruction register.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  7  instruction[6:0] from the instruction register.
- `funct3`  in  3  instruction[14:12].
- `funct7b5`  in  1  instruction[30].
- `zero`  in  1  ALU zero flag, combinational from the current ALU result.
- `mem_rdy`  in  1  memory access completes in this cycle.
- `pc_write`  out  1  PC register load enable.
- `ir_write`  out  1  instruction register and old-PC load enable.
- `mem_write`  out  1  data memory write request.
- `reg_write`  out  1  register file write enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `result_src`  out  2  result mux: 00 = ALUOut, 01 = mem data, 10 = ALU result.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b`  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_ctrl`  out  3  `alu_opcode_t` operation.
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction.
- `illegal_instr`  out  1  sticky trap flag.

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, TRAP.
- Defaults in every state: all strobes 0, selects 0, `alu_ctrl` = ADD.
- FETCH:
  - Drives `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, ADD, `result_src`=10.
  - Asserts `ir_write` and `pc_write` only when `mem_rdy`=1.
  - Holds in FETCH while `mem_rdy`=0; goes to DECODE when `mem_rdy`=1.
- DECODE:
  - Drives `alu_src_a`=01, `alu_src_b`=01, ADD, which precomputes the branch target.
  - Next state by `op`: 0000011/0100011 → MEM_ADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; 1101111 → JAL.
  - Any other `op` → TRAP.
  - ALU-class instruction with `funct3` not in {000, 010, 110, 111} → TRAP.
  - BRANCH with `funct3` ≠ 000 → TRAP.
- MEM_ADR:
  - Drives `alu_src_a`=10, `alu_src_b`=01, ADD.
  - Goes to MEM_READ if `op`[5]=0, else MEM_WRITE.
- MEM_READ:
  - Drives `adr_src`=1, `result_src`=00.
  - Holds until `mem_rdy`, then goes to MEM_WB.
- MEM_WB: `result_src`=01, `reg_write`=1, `instr_done`=1; goes to FETCH.
- MEM_WRITE:
  - Drives `adr_src`=1, `result_src`=00.
  - Holds `mem_write`=1 until `mem_rdy`; on that cycle `instr_done`=1, then goes to FETCH.
- EXEC_R: `alu_src_a`=10, `alu_src_b`=00, funct-decoded ALU op; goes to ALU_WB.
- EXEC_I: `alu_src_a`=10, `alu_src_b`=01, funct-decoded ALU op; goes to ALU_WB.
- ALU_WB: `result_src`=00, `reg_write`=1, `instr_done`=1; goes to FETCH.
- BRANCH:
  - Drives `alu_src_a`=10, `alu_src_b`=00, SUB, `result_src`=00.
  - `pc_write` = `zero`; `instr_done`=1; goes to FETCH.
- JAL:
  - Drives `alu_src_a`=01, `alu_src_b`=10, ADD, `result_src`=00, `pc_write`=1.
  - Goes to ALU_WB, which writes PC+4 to rd.
- TRAP: all strobes 0, `illegal_instr`=1; remains in TRAP until `rst`.
- Funct decode for ALU ops:
  - 000 → SUB if `op`=0110011 and `funct7b5`=1, otherwise ADD (addi ignores `funct7b5`).
  - 010 → SLT; 110 → OR; 111 → AND.
- `imm_src` is a combinational function of `op` in every state: lw/addi-class 00, sw 01, beq 10, jal 11, other 00.

## Timing
- State register updates on the rising edge of `clk`.
- All outputs are combinational from the state and inputs (Moore form, plus gating by `mem_rdy`/`zero`).
- Reset:
  - While `rst`=1, all strobes and `instr_done` are forced 0.
  - The next state is FETCH and `illegal_instr` clears to 0.
  - A reset mid-instruction aborts that instruction with no further strobes.
  - The first fetch strobe can occur in the first cycle after `rst` deasserts.
- Latency with zero wait states:
  - lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.
  - Each `mem_rdy`=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Handshake: a memory request is held stable, with the same address select and `mem_write`, until the cycle `mem_rdy`=1. `mem_rdy` is ignored in all other states.
- `instr_done` is exactly one cycle per retired instruction and is never asserted in TRAP.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with `mem_rdy`=1 → FETCH, DECODE, EXEC_R, ALU_WB; ADD in EXEC_R; `reg_write` and `instr_done` in cycle 4.
- `sub` (0x402081B3), then `addi` with `funct7b5`=1 (0x40008093) → SUB for the first, ADD for the second; `slt`/`or`/`and` funct3 values → SLT/OR/AND.
- `lw` (0x0000A183) with `mem_rdy` low for 2 cycles in MEM_READ → `adr_src`=1 held; MEM_WB with `result_src`=01 in cycle 7.
- `beq` with `zero`=1, then with `zero`=0 → `pc_write`=1, then 0, in BRANCH; 3 cycles each; `jal` → `pc_write` in JAL, `reg_write` in ALU_WB.
- Opcode 0x7F, or funct3 = 001 on an R-type → TRAP; `illegal_instr`=1 and all strobes 0 for 10 cycles; `rst` → `illegal_instr`=0 and state FETCH.
- `rst` asserted during MEM_WRITE with `mem_rdy`=0 → `mem_write` drops that cycle; normal fetch resumes after deassert.
